// File: rtl/bram_access_arbiter.sv
// Shares one single-port user BRAM between the Wishbone slave port and the accelerator
// request port. Grants are round-robin, and each access takes a fixed number of cycles.
module bram_access_arbiter #(
  parameter int unsigned DELAYS    = 10,      // wait cycles per access, 1..15
  parameter logic [11:0] BASE_ADDR = 12'h380  // wbs_adr_i[31:20] of the BRAM window
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_dat_i,
  input  logic [31:0] wbs_adr_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  input  logic        acc_req_i,
  input  logic        acc_we_i,
  input  logic [3:0]  acc_sel_i,
  input  logic [31:0] acc_dat_i,
  input  logic [31:0] acc_adr_i,
  output logic        acc_ack_o,
  output logic [31:0] acc_dat_o,
  output logic        ram_en_o,
  output logic [3:0]  ram_we_o,
  output logic [31:0] ram_adr_o,
  output logic [31:0] ram_di_o,
  input  logic [31:0] ram_do_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ACK  = 2'd2
  } state_t;

  typedef enum logic {
    OWN_WB  = 1'b0,
    OWN_ACC = 1'b1
  } owner_t;

  localparam logic [3:0] CNT_MAX = 4'(DELAYS);

  state_t      state_q, state_d;
  owner_t      owner_q, owner_d, last_owner_q;
  logic [3:0]  cnt_q;
  logic [31:0] adr_q, dat_q;
  logic [3:0]  sel_q;
  logic        we_q;
  logic        wb_abort_q;
  logic        wbs_ack_q, acc_ack_q;
  logic [31:0] wbs_rdata_q, acc_rdata_q;

  logic        wb_req;
  logic        grant;
  logic        busy;
  logic        cnt_done;
  logic [31:0] req_adr, req_dat;
  logic [3:0]  req_sel;
  logic        req_we;

  // Wishbone cycles outside the BRAM window are never claimed, hence never acked.
  assign wb_req   = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:20] == BASE_ADDR);
  assign busy     = (state_q == BUSY);
  assign cnt_done = busy && (cnt_q == CNT_MAX);

  // Next-state and grant decision.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    grant   = 1'b0;
    case (state_q)
      IDLE: begin
        if (wb_req || acc_req_i) begin
          grant   = 1'b1;
          state_d = BUSY;
          if (wb_req && acc_req_i) begin
            owner_d = (last_owner_q == OWN_WB) ? OWN_ACC : OWN_WB;
          end else if (wb_req) begin
            owner_d = OWN_WB;
          end else begin
            owner_d = OWN_ACC;
          end
        end
      end
      BUSY: begin
        if (cnt_done) state_d = ACK;
      end
      ACK: begin
        // Always pass through IDLE so a stb/req still high during ack is not re-granted.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Request fields of whichever port wins the grant.
  always_comb begin
    if (owner_d == OWN_WB) begin
      req_adr = wbs_adr_i;
      req_dat = wbs_dat_i;
      req_sel = wbs_sel_i;
      req_we  = wbs_we_i;
    end else begin
      req_adr = acc_adr_i;
      req_dat = acc_dat_i;
      req_sel = acc_sel_i;
      req_we  = acc_we_i;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values, independent of process ordering.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      owner_q      <= OWN_WB;
      last_owner_q <= OWN_ACC;
      cnt_q        <= '0;
      adr_q        <= '0;
      dat_q        <= '0;
      sel_q        <= '0;
      we_q         <= 1'b0;
      wb_abort_q   <= 1'b0;
      wbs_ack_q    <= 1'b0;
      acc_ack_q    <= 1'b0;
      wbs_rdata_q  <= '0;
      acc_rdata_q  <= '0;
    end else begin
      wbs_ack_q <= 1'b0;
      acc_ack_q <= 1'b0;

      if (grant) begin
        owner_q      <= owner_d;
        last_owner_q <= owner_d;
        adr_q        <= req_adr;
        dat_q        <= req_dat;
        sel_q        <= req_sel;
        we_q         <= req_we;
        cnt_q        <= '0;
        wb_abort_q   <= 1'b0;
      end

      if (busy) begin
        if (cnt_q != CNT_MAX) cnt_q <= cnt_q + 4'd1;
        // A dropped Wishbone cycle still finishes in the BRAM; only its ack is withheld.
        if (owner_q == OWN_WB && !wbs_cyc_i) wb_abort_q <= 1'b1;
        if (cnt_done) begin
          if (owner_q == OWN_WB) begin
            wbs_rdata_q <= ram_do_i;
            wbs_ack_q   <= !wb_abort_q && wbs_cyc_i;
          end else begin
            acc_rdata_q <= ram_do_i;
            acc_ack_q   <= 1'b1;
          end
        end
      end
    end
  end

  // Byte writes fire only in the first BUSY cycle; later BUSY cycles are pure reads.
  assign ram_en_o  = busy;
  assign ram_we_o  = (busy && cnt_q == 4'd0) ? (sel_q & {4{we_q}}) : 4'h0;
  assign ram_adr_o = busy ? adr_q : 32'h0;
  assign ram_di_o  = busy ? dat_q : 32'h0;

  assign wbs_ack_o = wbs_ack_q;
  assign wbs_dat_o = wbs_rdata_q;
  assign acc_ack_o = acc_ack_q;
  assign acc_dat_o = acc_rdata_q;

endmodule

// File: tb/tb_bram_access_arbiter.sv
// Bench for bram_access_arbiter: BRAM behavioural model, transaction-level reference
// (round-robin order, fixed latency, byte-merged memory image), directed and random steps.
module tb_bram_access_arbiter;

  localparam int D = 10;

  typedef struct {
    bit         we;
    logic [7:0] idx;
    logic [31:0] dat;
    logic [3:0] sel;
  } op_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wbs_stb_i = 1'b0, wbs_cyc_i = 1'b0, wbs_we_i = 1'b0;
  logic [3:0]  wbs_sel_i = '0;
  logic [31:0] wbs_dat_i = '0, wbs_adr_i = '0;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic        acc_req_i = 1'b0, acc_we_i = 1'b0;
  logic [3:0]  acc_sel_i = '0;
  logic [31:0] acc_dat_i = '0, acc_adr_i = '0;
  logic        acc_ack_o;
  logic [31:0] acc_dat_o;
  logic        ram_en_o;
  logic [3:0]  ram_we_o;
  logic [31:0] ram_adr_o, ram_di_o;
  logic [31:0] ram_do_i;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  bram_access_arbiter #(.DELAYS(D), .BASE_ADDR(12'h380)) dut (
    .wb_clk_i (clk),       .wb_rst_ni(rst_n),
    .wbs_stb_i(wbs_stb_i), .wbs_cyc_i(wbs_cyc_i), .wbs_we_i(wbs_we_i),
    .wbs_sel_i(wbs_sel_i), .wbs_dat_i(wbs_dat_i), .wbs_adr_i(wbs_adr_i),
    .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .acc_req_i(acc_req_i), .acc_we_i(acc_we_i),   .acc_sel_i(acc_sel_i),
    .acc_dat_i(acc_dat_i), .acc_adr_i(acc_adr_i),
    .acc_ack_o(acc_ack_o), .acc_dat_o(acc_dat_o),
    .ram_en_o (ram_en_o),  .ram_we_o (ram_we_o),  .ram_adr_o(ram_adr_o),
    .ram_di_o (ram_di_o),  .ram_do_i (ram_do_i)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Single-port BRAM with registered read; word index from byte address bits [9:2].
  logic [31:0] bram [0:255];
  initial for (int i = 0; i < 256; i++) bram[i] = '0;
  always @(posedge clk) begin
    if (ram_en_o) begin
      ram_do_i <= bram[ram_adr_o[9:2]];
      for (int b = 0; b < 4; b++)
        if (ram_we_o[b]) bram[ram_adr_o[9:2]][8*b +: 8] <= ram_di_o[8*b +: 8];
    end
  end

  // Event counters observed away from the active edge.
  int          wb_ack_cnt = 0, acc_ack_cnt = 0, we_cyc_cnt = 0, en_cyc_cnt = 0;
  logic [3:0]  last_we = '0;
  logic [31:0] last_we_adr = '0, last_we_dat = '0;
  always @(negedge clk) begin
    if (wbs_ack_o) wb_ack_cnt <= wb_ack_cnt + 1;
    if (acc_ack_o) acc_ack_cnt <= acc_ack_cnt + 1;
    if (ram_en_o)  en_cyc_cnt <= en_cyc_cnt + 1;
    if (ram_we_o != 4'h0) begin
      we_cyc_cnt  <= we_cyc_cnt + 1;
      last_we     <= ram_we_o;
      last_we_adr <= ram_adr_o;
      last_we_dat <= ram_di_o;
    end
  end

  // Reference model: memory image, next free grant edge, last granted port.
  logic [31:0] ref_mem [0:255];
  int          free_edge = 0;
  bit          rr_last_acc = 1'b1;
  initial for (int i = 0; i < 256; i++) ref_mem[i] = '0;

  function automatic logic [31:0] wadr(input logic [7:0] idx);
    return {12'h380, 10'h000, idx, 2'b00};
  endfunction

  function automatic logic [31:0] ref_access(input bit we, input logic [7:0] idx,
                                             input logic [31:0] dat, input logic [3:0] sel);
    if (we)
      for (int b = 0; b < 4; b++)
        if (sel[b]) ref_mem[idx][8*b +: 8] = dat[8*b +: 8];
    return ref_mem[idx];
  endfunction

  // Request visible from edge req+1 on; returns the cycle count at which ack is seen.
  function automatic int predict(input int req, input bit is_acc);
    int g;
    g = (req + 1 > free_edge) ? req + 1 : free_edge;
    free_edge   = g + D + 3;
    rr_last_acc = is_acc;
    return g + D + 1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_ram_en"},  {31'h0, ram_en_o},  32'h0);
    check({tag, "_ram_we"},  {28'h0, ram_we_o},  32'h0);
    check({tag, "_ram_adr"}, ram_adr_o,          32'h0);
    check({tag, "_ram_di"},  ram_di_o,           32'h0);
    check({tag, "_wbs_ack"}, {31'h0, wbs_ack_o}, 32'h0);
    check({tag, "_acc_ack"}, {31'h0, acc_ack_o}, 32'h0);
    check({tag, "_wbs_dat"}, wbs_dat_o,          32'h0);
    check({tag, "_acc_dat"}, acc_dat_o,          32'h0);
  endtask

  // One request on one port, held until ack or until the cycle budget runs out.
  // Called at posedge+1; returns at posedge+1 with the request dropped.
  task automatic xfer(input bit is_acc, input bit we, input logic [31:0] adr, input logic [31:0] dat,
                      input logic [3:0] sel, input int budget, output bit acked,
                      output logic [31:0] rdata, output int req_cyc, output int ack_cyc);
    req_cyc = cyc;
    acked   = 1'b0;
    rdata   = '0;
    ack_cyc = -1;
    if (is_acc) begin
      acc_req_i = 1'b1; acc_we_i = we; acc_adr_i = adr; acc_dat_i = dat; acc_sel_i = sel;
    end else begin
      wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = we;
      wbs_adr_i = adr;  wbs_dat_i = dat;  wbs_sel_i = sel;
    end
    for (int i = 0; i < budget && !acked; i++) begin
      @(negedge clk);
      if (is_acc ? acc_ack_o : wbs_ack_o) begin
        acked   = 1'b1;
        rdata   = is_acc ? acc_dat_o : wbs_dat_o;
        ack_cyc = cyc;
      end
    end
    @(posedge clk); #1;
    if (is_acc) acc_req_i = 1'b0;
    else begin
      wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0;
    end
  endtask

  // n ops per enabled port, all requests raised together and re-raised right after each ack.
  task automatic run_ops(input string tag, input int n, input bit use_wb, input bit use_acc,
                         input op_t wb_ops[2], input op_t acc_ops[2]);
    bit          ok_w[2], ok_a[2];
    logic [31:0] rd_w[2], rd_a[2];
    int          ak_w[2], ak_a[2];
    int          rq_w, rq_a, r, jw, ja, total, ea;
    bit          owner;
    op_t         op;
    logic [31:0] ed;
    r = cyc;
    fork
      begin
        if (use_wb)
          for (int j = 0; j < n; j++)
            xfer(1'b0, wb_ops[j].we, wadr(wb_ops[j].idx), wb_ops[j].dat, wb_ops[j].sel, 80,
                 ok_w[j], rd_w[j], rq_w, ak_w[j]);
      end
      begin
        if (use_acc)
          for (int j = 0; j < n; j++)
            xfer(1'b1, acc_ops[j].we, wadr(acc_ops[j].idx), acc_ops[j].dat, acc_ops[j].sel, 80,
                 ok_a[j], rd_a[j], rq_a, ak_a[j]);
      end
    join
    jw    = 0;
    ja    = 0;
    total = (int'(use_wb) + int'(use_acc)) * n;
    owner = (use_wb && use_acc) ? !rr_last_acc : use_acc;
    for (int k = 0; k < total; k++) begin
      op = owner ? acc_ops[ja] : wb_ops[jw];
      ea = predict(r, owner);
      ed = ref_access(op.we, op.idx, op.dat, op.sel);
      if (owner) begin
        check($sformatf("%s_acc%0d_acked", tag, ja), {31'h0, ok_a[ja]}, 32'h1);
        check($sformatf("%s_acc%0d_ack_cyc", tag, ja), ak_a[ja], ea);
        if (!op.we) check($sformatf("%s_acc%0d_rdata", tag, ja), rd_a[ja], ed);
        ja++;
      end else begin
        check($sformatf("%s_wb%0d_acked", tag, jw), {31'h0, ok_w[jw]}, 32'h1);
        check($sformatf("%s_wb%0d_ack_cyc", tag, jw), ak_w[jw], ea);
        if (!op.we) check($sformatf("%s_wb%0d_rdata", tag, jw), rd_w[jw], ed);
        jw++;
      end
      if (use_wb && use_acc) owner = !owner;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=no finish expected=finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    op_t         wo[2], ao[2];
    bit          ok, ok2;
    logic [31:0] rd, rd2, d6, exp_d;
    int          rq, rq2, ak, ak2, r, ea, e0, w0, a0, we0;

    // Reset state.
    #1;
    check_outputs_zero("reset");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check_outputs_zero("post_reset_idle");

    // Reset asserted in the middle of a BUSY write.
    wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = 1'b1;
    wbs_adr_i = wadr(8'd20); wbs_dat_i = 32'h1234_5678; wbs_sel_i = 4'hF;
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check_outputs_zero("mid_busy_reset");
    wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    ed_unused_write: begin
      exp_d = ref_access(1'b1, 8'd20, 32'h1234_5678, 4'hF);
    end
    free_edge   = 0;
    rr_last_acc = 1'b1;
    @(posedge clk); #1;
    check("reset_write_kept", bram[20], exp_d);

    // Both ports held for two accesses each: WB,ACC,WB,ACC, 13 cycles apart.
    wo[0] = '{1'b1, 8'd1, $urandom, 4'hF};
    wo[1] = '{1'b1, 8'd2, $urandom, 4'b0110};
    ao[0] = '{1'b0, 8'd1, 32'h0, 4'hF};
    ao[1] = '{1'b0, 8'd2, 32'h0, 4'hF};
    run_ops("tie", 2, 1'b1, 1'b1, wo, ao);

    // Wishbone full-word write, then read-back.
    we0 = we_cyc_cnt; w0 = wb_ack_cnt;
    wo[0] = '{1'b1, 8'd4, 32'hDEAD_BEEF, 4'hF};
    run_ops("wr", 1, 1'b1, 1'b0, wo, ao);
    repeat (2) @(posedge clk); #1;
    check("wr_we_cycles", we_cyc_cnt - we0, 1);
    check("wr_we_mask", {28'h0, last_we}, 32'hF);
    check("wr_we_adr", last_we_adr, 32'h3800_0010);
    check("wr_we_dat", last_we_dat, 32'hDEAD_BEEF);
    check("wr_ack_pulses", wb_ack_cnt - w0, 1);

    a0 = acc_ack_cnt;
    wo[0] = '{1'b0, 8'd4, 32'h0, 4'hF};
    run_ops("rd", 1, 1'b1, 1'b0, wo, ao);
    repeat (2) @(posedge clk); #1;
    check("rd_no_acc_ack", acc_ack_cnt - a0, 0);

    // Out-of-window Wishbone address with a concurrent accelerator write.
    e0 = en_cyc_cnt; w0 = wb_ack_cnt; r = cyc;
    d6 = $urandom;
    fork
      xfer(1'b0, 1'b0, 32'h3000_0000, 32'h0, 4'hF, 30, ok, rd, rq, ak);
      xfer(1'b1, 1'b1, wadr(8'd6), d6, 4'b1010, 60, ok2, rd2, rq2, ak2);
    join
    ea = predict(r, 1'b1);
    exp_d = ref_access(1'b1, 8'd6, d6, 4'b1010);
    check("oow_wb_not_acked", {31'h0, ok}, 32'h0);
    check("oow_wb_ack_pulses", wb_ack_cnt - w0, 0);
    check("oow_acc_acked", {31'h0, ok2}, 32'h1);
    check("oow_acc_ack_cyc", ak2, ea);
    check("oow_en_cycles", en_cyc_cnt - e0, D + 1);
    check("oow_bram_word", bram[6], exp_d);

    // Wishbone write aborted at cnt=3, accelerator reads the same word afterwards.
    w0 = wb_ack_cnt; we0 = we_cyc_cnt; r = cyc;
    d6 = $urandom;
    wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = 1'b1;
    wbs_adr_i = wadr(8'd9); wbs_dat_i = d6; wbs_sel_i = 4'hF;
    repeat (4) @(posedge clk);
    #1 wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0;
    void'(predict(r, 1'b0));
    void'(ref_access(1'b1, 8'd9, d6, 4'hF));
    xfer(1'b1, 1'b0, wadr(8'd9), 32'h0, 4'hF, 60, ok, rd, rq, ak);
    ea = predict(rq, 1'b1);
    exp_d = ref_access(1'b0, 8'd9, 32'h0, 4'hF);
    repeat (2) @(posedge clk); #1;
    check("abort_no_wb_ack", wb_ack_cnt - w0, 0);
    check("abort_we_cycles", we_cyc_cnt - we0, 1);
    check("abort_bram_word", bram[9], exp_d);
    check("abort_acc_acked", {31'h0, ok}, 32'h1);
    check("abort_acc_ack_cyc", ak, ea);
    check("abort_acc_rdata", rd, exp_d);

    // Random single and concurrent accesses on a small set of words.
    for (int it = 0; it < 12; it++) begin
      int mode;
      mode = $urandom_range(0, 2);
      wo[0] = '{bit'($urandom_range(0, 1)), 8'($urandom_range(0, 7)), $urandom, 4'($urandom_range(1, 15))};
      ao[0] = '{bit'($urandom_range(0, 1)), 8'($urandom_range(0, 7)), $urandom, 4'($urandom_range(1, 15))};
      run_ops($sformatf("rnd%0d", it), 1, mode != 1, mode != 0, wo, ao);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
